// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding and
// channel-mask scanning functions.
package rst_seq_pkg;

   typedef enum logic [1:0] {HOLD, RELEASE, RUN} rst_seq_state_t;

   localparam int unsigned MAX_CH = 16;

   typedef struct packed {
      logic       found;
      logic [3:0] idx;
   } bit_sel_t;

   // Lowest set bit of mask at or above position 'from'.
   function automatic bit_sel_t next_set_bit(input logic [MAX_CH-1:0] mask,
                                             input int unsigned       from);
      bit_sel_t r;
      r.found = 1'b0;
      r.idx   = '0;
      for (int unsigned i = 0; i < MAX_CH; i++) begin
         if (!r.found && mask[i] && (i >= from)) begin
            r.found = 1'b1;
            r.idx   = 4'(i);
         end
      end
      return r;
   endfunction

   function automatic logic has_set_bit(input logic [MAX_CH-1:0] mask,
                                        input int unsigned       from);
      logic any;
      any = 1'b0;
      for (int unsigned i = 0; i < MAX_CH; i++) begin
         if (mask[i] && (i >= from)) any = 1'b1;
      end
      return any;
   endfunction

endpackage

// File: rtl/rst_seq_ctrl_sync.sv
// Reset synchronizer: asynchronous assertion, release after SYNC_STAGES
// rising clock edges.
module rst_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   output logic rst_sync_n
);

   logic [SYNC_STAGES-1:0] chain_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) chain_q <= '0;
      else        chain_q <= {chain_q[SYNC_STAGES-2:0], 1'b1};
   end

   assign rst_sync_n = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Staggered per-channel reset sequencer with software re-sequence and enable mask.
// Optional status counters (uptime, seq_count) when RST_SEQ_STATUS_EN is defined.
module rst_seq_ctrl
   import rst_seq_pkg::*;
#(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned HOLD_CYCLES = 10,
   parameter int unsigned STAGGER     = 5,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sw_rst_req,
   input  logic [NUM_CH-1:0] ch_en,
   output logic [NUM_CH-1:0] ch_rst_n,
   output logic              busy,
   output logic              done
`ifdef RST_SEQ_STATUS_EN
   ,
   output logic [31:0]       uptime,
   output logic [7:0]        seq_count
`endif
);

   localparam int unsigned CNT_MAX = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic rst_sync_n;

   rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .rst_sync_n (rst_sync_n)
   );

   rst_seq_state_t    state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [NUM_CH-1:0] en_q, en_d;
   logic [NUM_CH-1:0] ch_q, ch_d;

   logic [NUM_CH-1:0] hold_mask;
   bit_sel_t          first_sel, next_sel;
   logic              more_after_first, more_after_next;

   always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         state_q <= HOLD;
         cnt_q   <= '0;
         idx_q   <= '0;
         en_q    <= '0;
         ch_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         en_q    <= en_d;
         ch_q    <= ch_d;
      end
   end

   // On the last HOLD cycle the mask may not be latched yet (HOLD_CYCLES==1),
   // so the first-cycle decision looks at ch_en directly.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      en_d    = en_q;
      ch_d    = ch_q;

      hold_mask        = (cnt_q == '0) ? ch_en : en_q;
      first_sel        = next_set_bit(MAX_CH'(hold_mask), 0);
      more_after_first = has_set_bit(MAX_CH'(hold_mask), 32'(first_sel.idx) + 32'd1);
      next_sel         = next_set_bit(MAX_CH'(en_q), 32'(idx_q) + 32'd1);
      more_after_next  = has_set_bit(MAX_CH'(en_q), 32'(next_sel.idx) + 32'd1);

      if (sw_rst_req) begin
         state_d = HOLD;
         cnt_d   = '0;
         idx_d   = '0;
         en_d    = ch_en;
         ch_d    = '0;
      end else begin
         unique case (state_q)
            HOLD: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == '0) en_d = ch_en;
               if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                  cnt_d = '0;
                  if (!first_sel.found) begin
                     state_d = RUN;
                  end else begin
                     ch_d[IDX_W'(first_sel.idx)] = 1'b1;
                     idx_d   = IDX_W'(first_sel.idx);
                     state_d = more_after_first ? RELEASE : RUN;
                  end
               end
            end
            RELEASE: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(STAGGER - 1)) begin
                  cnt_d = '0;
                  if (next_sel.found) begin
                     ch_d[IDX_W'(next_sel.idx)] = 1'b1;
                     idx_d = IDX_W'(next_sel.idx);
                  end
                  if (!next_sel.found || !more_after_next) state_d = RUN;
               end
            end
            RUN: ;
            default: state_d = HOLD;
         endcase
      end
   end

   assign ch_rst_n = ch_q;
   assign done     = (state_q == RUN);
   assign busy     = rst_sync_n && (state_q != RUN);

`ifdef RST_SEQ_STATUS_EN
   logic [31:0] uptime_q;
   logic [7:0]  seq_q;

   always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         uptime_q <= '0;
         seq_q    <= '0;
      end else begin
         if (sw_rst_req)
            uptime_q <= '0;
         else if ((state_q == RUN) && (uptime_q != '1))
            uptime_q <= uptime_q + 32'd1;
         if ((state_q != RUN) && (state_d == RUN))
            seq_q <= seq_q + 8'd1;
      end
   end

   assign uptime    = uptime_q;
   assign seq_count = seq_q;
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl: release times derived arithmetically from
// the sequence start edge and the enable mask; RST_SEQ_STATUS_EN adds counter checks.
module tb_rst_seq_ctrl;

   localparam int N  = 4;
   localparam int H  = 10;
   localparam int ST = 5;
   localparam int SS = 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         sw_rst_req;
   logic [N-1:0] ch_en;
   logic [N-1:0] ch_rst_n;
   logic         busy;
   logic         done;
`ifdef RST_SEQ_STATUS_EN
   logic [31:0]  uptime;
   logic [7:0]   seq_count;
`endif

   rst_seq_ctrl #(
      .NUM_CH      (N),
      .HOLD_CYCLES (H),
      .STAGGER     (ST),
      .SYNC_STAGES (SS)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sw_rst_req (sw_rst_req),
      .ch_en      (ch_en),
      .ch_rst_n   (ch_rst_n),
      .busy       (busy),
      .done       (done)
`ifdef RST_SEQ_STATUS_EN
      ,
      .uptime     (uptime),
      .seq_count  (seq_count)
`endif
   );

   always #5 clk = ~clk;

   int edge_n = 0;
   always @(posedge clk) edge_n++;

   int           checks   = 0;
   int           failures = 0;
   int           seq_s    = 1 << 30;
   int           exp_seq  = 0;
   logic [N-1:0] mdl_mask;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         failures++;
         $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, edge_n, obs, want);
      end
   endtask

   function automatic int done_time(input logic [N-1:0] m);
      int k = 0;
      for (int c = 0; c < N; c++) if (m[c]) k++;
      return H + ((k > 0) ? (k - 1) * ST : 0);
   endfunction

   task automatic check_cycle();
      int           t, k, dt;
      logic [N-1:0] e_ch;
      logic         e_done, e_busy;
      t    = edge_n - seq_s;
      e_ch = '0;
      k    = 0;
      for (int c = 0; c < N; c++) begin
         if (mdl_mask[c]) begin
            if (t >= H + ST * k) e_ch[c] = 1'b1;
            k++;
         end
      end
      dt = done_time(mdl_mask);
      if (t < 0) begin
         e_ch   = '0;
         e_done = 1'b0;
         e_busy = 1'b0;
      end else begin
         e_done = (t >= dt);
         e_busy = !e_done;
      end
      chk("ch_rst_n", 32'(ch_rst_n), 32'(e_ch));
      chk("done",     32'(done),     32'(e_done));
      chk("busy",     32'(busy),     32'(e_busy));
`ifdef RST_SEQ_STATUS_EN
      if (t == dt) exp_seq++;
      chk("uptime",    uptime,          (t >= dt) ? 32'(t - dt) : 32'd0);
      chk("seq_count", 32'(seq_count),  32'(exp_seq & 8'hFF));
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      check_cycle();
   endtask

   // Advance until the sequence is t_end edges old; ch_en is scrambled once in RUN.
   task automatic run_to(input int t_end);
      while (edge_n - seq_s < t_end) begin
         if (edge_n - seq_s >= done_time(mdl_mask)) ch_en = N'($urandom);
         tick();
      end
   endtask

   task automatic start_sw(input logic [N-1:0] m);
      ch_en      = m;
      mdl_mask   = m;
      sw_rst_req = 1'b1;
      seq_s      = edge_n + 1;
      tick();
      sw_rst_req = 1'b0;
   endtask

   initial begin
      rst_n      = 1'b1;
      sw_rst_req = 1'b0;
      ch_en      = 4'b1111;
      mdl_mask   = 4'b1111;
      #2 rst_n = 1'b0;
      #1 check_cycle();
      tick();
      tick();

      // Power-on release mid-cycle; sync chain adds SS edges.
      rst_n = 1'b1;
      seq_s = edge_n + SS;
      run_to(done_time(mdl_mask) + 100);

      start_sw(4'b1010);
      run_to(done_time(4'b1010) + 4);

      start_sw(4'b0000);
      run_to(done_time(4'b0000) + 4);

      // Re-request two cycles after channel 1 releases.
      start_sw(4'b1111);
      run_to(H + ST + 2);
      start_sw(4'b1111);
      run_to(done_time(4'b1111) + 3);

      // Restart while still in HOLD.
      start_sw(4'b0110);
      run_to(4);
      start_sw(4'b0110);
      run_to(done_time(4'b0110) + 3);

      for (int i = 0; i < 8; i++) begin
         logic [N-1:0] m;
         m = N'($urandom_range(0, 15));
         start_sw(m);
         if ($urandom_range(0, 2) == 0) run_to($urandom_range(1, done_time(m)));
         else                           run_to(done_time(m) + 3);
      end

      // Asynchronous abort mid-RELEASE, between clock edges.
      start_sw(4'b1111);
      run_to(H + 7);
      #3 rst_n = 1'b0;
      seq_s   = 1 << 30;
      exp_seq = 0;
      #1 check_cycle();
      tick();
      tick();
      rst_n = 1'b1;
      seq_s = edge_n + SS;
      run_to(done_time(mdl_mask) + 5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
- Parametrised reset sequencer that turns one board-level asynchronous active-low reset into NUM_CH staggered, per-channel synchronous-release resets.
- Replaces ad-hoc "deassert reset, wait N ns, wait clock edge" sequencing in benches and top levels with a synthesizable, counted block.
- Sits directly under the top level and drives the reset inputs of every downstream block.
- Also supports a software-requested re-sequence and a per-channel enable mask.

Parameters:
- NUM_CH, 4: number of output reset channels (1..16).
- HOLD_CYCLES, 10: cycles all channels stay held after synchronized reset release (>=1).
- STAGGER, 5: cycles between consecutive enabled channel releases (>=1).
- SYNC_STAGES, 2: depth of the reset synchronizer chain (>=2).

Ports:
- clk  in  1  system clock; all logic is on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- sw_rst_req  in  1  single-cycle request to re-run the full sequence.
- ch_en  in  NUM_CH  channel enable mask; sampled on HOLD entry.
- ch_rst_n  out  NUM_CH  per-channel active-low reset.
- busy  out  1  high while a sequence is in progress.
- done  out  1  high once all enabled channels are released.

Behaviour:
- Reset assertion:
  - rst_n low asynchronously clears the synchronizer, ch_rst_n, done and busy (all 0).
  - The FSM goes to HOLD with hold counter 0.
- Reset release:
  - A SYNC_STAGES flop chain shifts in 1; rst_sync_n rises SYNC_STAGES posedges after rst_n rises.
  - All other logic is reset by rst_sync_n.
- busy:
  - Driven to 1 in HOLD and RELEASE once rst_sync_n is high.
  - 0 in RUN.
- FSM, three states:
  - HOLD:
    - Hold counter increments each cycle; ch_en is latched into en_q on the first HOLD cycle.
    - At count HOLD_CYCLES-1, go to RELEASE with idx set to the lowest set bit of en_q.
    - If en_q == 0, go straight to RUN.
  - RELEASE:
    - On entry, ch_rst_n[idx] <= 1.
    - Wait STAGGER cycles, then move idx to the next set bit of en_q.
    - Disabled channels consume no cycles and stay at 0.
    - After the highest enabled channel is released, go to RUN on that same edge.
  - RUN:
    - done = 1, busy = 0.
    - ch_rst_n is stable; ch_en changes are ignored until the next sequence.
- Release timing:
  - First enabled channel rises HOLD_CYCLES edges after rst_sync_n rises.
  - The j-th enabled channel (0-based) rises j*STAGGER edges later.
  - done rises on the same edge as the last enabled release.
- sw_rst_req in any state (including mid-HOLD and mid-RELEASE):
  - Next edge: ch_rst_n = 0, done = 0, busy = 1, FSM in HOLD with counter 0, en_q re-sampled.
  - A request arriving while already in HOLD restarts the count.
- rst_n low mid-sequence aborts asynchronously, as under Reset assertion.
- Counter widths: $clog2(max(HOLD_CYCLES, STAGGER)+1); idx is $clog2(NUM_CH) bits, minimum 1.

Optional Feature:
- RST_SEQ_STATUS_EN defined adds two output ports:
  - uptime [31:0]: counts cycles in RUN, saturating at 0xFFFF_FFFF, cleared on entry to HOLD.
  - seq_count [7:0]: counts completed sequences (entries to RUN), wraps at 255, cleared only by rst_n.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package rst_seq_pkg holds:
  - typedef enum logic [1:0] {HOLD, RELEASE, RUN} rst_seq_state_t;
  - a helper function next_set_bit(mask, from) returning the index and a found flag.
- Sub-module rst_sync (parameter SYNC_STAGES; ports clk, rst_n, rst_sync_n) holds the async-assert / sync-release chain. It is reusable elsewhere.

Test Plan:
- Defaults, ch_en=4'b1111, 10 ns clock, rst_n released at 5 ns -> rst_sync_n high 2 edges later; ch_rst_n[0..3] rise 10, 15, 20, 25 edges after that; done rises with ch_rst_n[3]; busy falls on the same edge.
- ch_en=4'b1010 -> ch_rst_n[1] rises 10 edges after sync release and ch_rst_n[3] 5 edges after that; bits 0 and 2 stay 0; done rises with bit 3.
- ch_en=4'b0000 -> done rises 10 edges after sync release; all ch_rst_n stay 0.
- sw_rst_req pulsed 2 cycles after ch_rst_n[1] rises -> all ch_rst_n=0 and done=0 next edge; full sequence repeats from HOLD count 0.
- rst_n driven low mid-RELEASE, between edges -> ch_rst_n, done and busy go 0 with no clock edge; the sequence restarts after release.
- RST_SEQ_STATUS_EN defined -> 100 cycles in RUN gives uptime=100; a sw_rst_req clears uptime; seq_count goes 1 -> 2.
